// File: rtl/switch_debouncer_if.sv
// Signal bundle between the board switch inputs and the debounced switch register.
// The debouncer is the slave; the switch register / board side is the master.
interface switch_debouncer_if;
  logic [63:0] dip_raw;
  logic [7:0]  key_raw;
  logic        irq_ack;
  logic [63:0] dip_stable;
  logic [7:0]  key_stable;
  logic [7:0]  key_press;
  logic        irq;

  modport master (
    output dip_raw, key_raw, irq_ack,
    input  dip_stable, key_stable, key_press, irq
  );

  modport slave (
    input  dip_raw, key_raw, irq_ack,
    output dip_stable, key_stable, key_press, irq
  );
endinterface

// File: rtl/switch_debouncer.sv
// Debounces 8 active-low DIP switch bytes plus 8 push buttons as 9 independent groups.
// Raises key_press on accepted presses and a sticky irq whenever any debounced group changes.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 500000
) (
  input logic               clk,
  input logic               reset,
  switch_debouncer_if.slave bus
);

  localparam int          NUM_GROUPS = 9;
  localparam logic [19:0] LAST_COUNT = 20'(STABLE_CYCLES - 1);

  logic [NUM_GROUPS-1:0][7:0]  raw_grp;
  logic [NUM_GROUPS-1:0][7:0]  sync1;
  logic [NUM_GROUPS-1:0][7:0]  sync2;
  logic [NUM_GROUPS-1:0][7:0]  candidate;
  logic [NUM_GROUPS-1:0][7:0]  stable;
  logic [NUM_GROUPS-1:0][7:0]  stable_q;
  logic [NUM_GROUPS-1:0][19:0] count;
  logic [7:0]                  key_press;
  logic                        irq;

  // Group 8 is the key byte, groups 0..7 are the DIP bytes.
  assign raw_grp = {bus.key_raw, bus.dip_raw};

  // Each group's candidate must stay unchanged for STABLE_CYCLES samples before it is
  // copied to stable; any difference restarts only that group's counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '1;
      sync2     <= '1;
      candidate <= '1;
      stable    <= '1;
      count     <= '0;
    end else begin
      sync1 <= raw_grp;
      sync2 <= sync1;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (sync2[g] != candidate[g]) begin
          candidate[g] <= sync2[g];
          count[g]     <= '0;
        end else if (count[g] < LAST_COUNT) begin
          count[g] <= count[g] + 20'd1;
        end else begin
          stable[g] <= candidate[g];
        end
      end
    end
  end

  // Change detection runs one cycle behind stable, so a saturated reload with the same
  // value produces no event; a set on the same edge as an ack keeps irq high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q  <= '1;
      key_press <= '0;
      irq       <= 1'b0;
    end else begin
      stable_q  <= stable;
      key_press <= stable_q[8] & ~stable[8];
      irq       <= (stable != stable_q) | (irq & ~bus.irq_ack);
    end
  end

  assign bus.dip_stable = stable[7:0];
  assign bus.key_stable = stable[8];
  assign bus.key_press  = key_press;
  assign bus.irq        = irq;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with STABLE_CYCLES=4: stimulus queues timed output
// events, a monitor pops one whenever the DUT outputs change and compares time and value.
module tb_switch_debouncer;

  localparam int STABLE = 4;

  typedef struct {
    int          at;
    logic [63:0] dip;
    logic [7:0]  key;
    logic [7:0]  press;
    logic        irq;
  } event_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  event_t      sb[$];
  logic [63:0] exp_dip = '1;
  logic [7:0]  exp_key = '1;

  switch_debouncer_if bus ();

  switch_debouncer #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  task automatic expect_at(input int at, input logic [7:0] press, input logic irq);
    event_t e;
    e.at    = at;
    e.dip   = exp_dip;
    e.key   = exp_key;
    e.press = press;
    e.irq   = irq;
    sb.push_back(e);
  endtask

  task automatic do_ack();
    expect_at(cyc + 1, 8'h00, 1'b0);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
  endtask

  // Monitor: any output change while out of reset must match the next queued event.
  initial begin
    logic [63:0] last_dip;
    logic [7:0]  last_key;
    logic [7:0]  last_press;
    logic        last_irq;
    event_t      e;
    last_dip   = '1;
    last_key   = '1;
    last_press = '0;
    last_irq   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && ({bus.dip_stable, bus.key_stable, bus.key_press, bus.irq} !=
                    {last_dip, last_key, last_press, last_irq})) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event at cycle %0d: got dip=%h key=%h press=%h irq=%b, required no change",
                   cyc, bus.dip_stable, bus.key_stable, bus.key_press, bus.irq);
        end else begin
          e = sb.pop_front();
          check_output("event_cycle", 64'(cyc), 64'(e.at));
          check_output("event_dip", bus.dip_stable, e.dip);
          check_output("event_key", 64'(bus.key_stable), 64'(e.key));
          check_output("event_press", 64'(bus.key_press), 64'(e.press));
          check_output("event_irq", 64'(bus.irq), 64'(e.irq));
        end
      end
      last_dip   = bus.dip_stable;
      last_key   = bus.key_stable;
      last_press = bus.key_press;
      last_irq   = bus.irq;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: inputs change on the falling edge; "edge 1" is the next rising edge.
  initial begin
    int n;
    int r;
    bus.dip_raw = '1;
    bus.key_raw = '1;
    bus.irq_ack = 1'b0;
    reset       = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_dip", bus.dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("reset_key", 64'(bus.key_stable), 64'hFF);
    check_output("reset_press", 64'(bus.key_press), 64'h0);
    check_output("reset_irq", 64'(bus.irq), 64'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Clean change on byte 0.
    n = cyc;
    bus.dip_raw[7:0] = 8'h5A;
    exp_dip[7:0]     = 8'h5A;
    expect_at(n + 7, 8'h00, 1'b0);
    expect_at(n + 8, 8'h00, 1'b1);
    repeat (6) @(negedge clk);
    check_output("clean_no_early", bus.dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (4) @(negedge clk);
    do_ack();

    // Glitch of 3 cycles on bit 63.
    bus.dip_raw[63] = 1'b0;
    repeat (3) @(negedge clk);
    bus.dip_raw[63] = 1'b1;
    repeat (15) @(negedge clk);
    check_output("glitch_dip", bus.dip_stable, exp_dip);
    check_output("glitch_irq", 64'(bus.irq), 64'h0);

    // Bouncing key 0, then held pressed.
    n = cyc;
    for (int k = 0; k < 10; k++) begin
      bus.key_raw[0] = (k % 2 == 1);
      repeat (2) @(negedge clk);
    end
    bus.key_raw[0] = 1'b0;
    exp_key        = 8'hFE;
    expect_at(n + 27, 8'h00, 1'b0);
    expect_at(n + 28, 8'h01, 1'b1);
    expect_at(n + 29, 8'h00, 1'b1);
    repeat (12) @(negedge clk);
    do_ack();

    // Key release: irq but no press pulse.
    n = cyc;
    bus.key_raw[0] = 1'b1;
    exp_key        = 8'hFF;
    expect_at(n + 7, 8'h00, 1'b0);
    expect_at(n + 8, 8'h00, 1'b1);
    repeat (12) @(negedge clk);
    do_ack();

    // Ack race: ack on the same edge a new change sets irq.
    n = cyc;
    bus.dip_raw[47:40] = 8'hC3;
    exp_dip[47:40]     = 8'hC3;
    expect_at(n + 7, 8'h00, 1'b0);
    expect_at(n + 8, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    n = cyc;
    bus.dip_raw[55:48] = 8'h3C;
    exp_dip[55:48]     = 8'h3C;
    expect_at(n + 7, 8'h00, 1'b1);
    repeat (7) @(negedge clk);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    check_output("ack_race_irq", 64'(bus.irq), 64'h1);
    repeat (3) @(negedge clk);
    do_ack();

    // Reset asserted mid-count on byte 3.
    n = cyc;
    bus.dip_raw[31:24] = 8'h00;
    exp_dip[31:24]     = 8'h00;
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("midreset_dip", bus.dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("midreset_key", 64'(bus.key_stable), 64'hFF);
    check_output("midreset_irq", 64'(bus.irq), 64'h0);
    repeat (3) @(negedge clk);
    r = cyc;
    reset = 1'b1;
    expect_at(r + 7, 8'h00, 1'b0);
    expect_at(r + 8, 8'h00, 1'b1);
    repeat (6) @(negedge clk);
    check_output("postreset_no_early", bus.dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (6) @(negedge clk);
    do_ack();

    // Independence: byte 1 never settles while byte 2 changes once.
    n = cyc;
    bus.dip_raw[23:16] = 8'h96;
    exp_dip[23:16]     = 8'h96;
    expect_at(n + 7, 8'h00, 1'b0);
    expect_at(n + 8, 8'h00, 1'b1);
    for (int k = 0; k < 30; k++) begin
      bus.dip_raw[15:8] = (k % 2 == 0) ? 8'h11 : 8'h22;
      @(negedge clk);
    end
    bus.dip_raw[15:8] = 8'hFF;
    repeat (15) @(negedge clk);
    check_output("indep_byte1", 64'(bus.dip_stable[15:8]), 64'hFF);
    do_ack();
    repeat (5) @(negedge clk);

    check_output("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 500000, meaning consecutive clock cycles an input group must hold unchanged before it is accepted; legal range 2..2^20-1.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-004 SHALL have port dip_raw  input  64  raw board DIP switches, active-low; byte g (bits 8g+7..8g) is switch group g, g = 0..7.
REQ-005 SHALL have port key_raw  input  8  raw push buttons, active-low (0 = pressed); treated as group 8.
REQ-006 SHALL have port irq_ack  input  1  one-cycle acknowledge that clears irq.
REQ-007 SHALL have port dip_stable  output  64  debounced DIP value, raw polarity (not inverted); byte g maps to dip_switchg of the downstream switch register.
REQ-008 SHALL have port key_stable  output  8  debounced key value, raw polarity.
REQ-009 SHALL have port key_press  output  8  one-cycle pulse per key on an accepted press.
REQ-010 SHALL have port irq  output  1  sticky flag: some debounced group changed since the last ack.

Function
REQ-011 SHALL pass all 72 raw bits through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL keep, per group (9 groups, 8 bits each), a candidate register, a stable register and a 20-bit counter.
REQ-013 SHALL, when sync2 of a group differs from its candidate, load candidate with sync2 and clear that group's counter in the same cycle.
REQ-014 SHALL, when sync2 equals candidate and counter < STABLE_CYCLES-1, increment the counter by 1.
REQ-015 SHALL, when sync2 equals candidate and counter == STABLE_CYCLES-1, load stable with candidate and hold the counter (saturate; no wrap).
REQ-016 SHALL, for a clean raw change first sampled by sync1 at edge 1, update the group's stable output at edge STABLE_CYCLES+3, with no earlier change.
REQ-017 SHALL discard any glitch: a raw pulse shorter than STABLE_CYCLES cycles never reaches the stable output, and each bounce restarts the counter.
REQ-018 SHALL debounce groups independently; activity in one group never resets or delays another group's counter.
REQ-019 SHALL assert key_press[i] for exactly one cycle, on the cycle after key_stable[i] changes from 1 to 0; a release (0->1) produces no pulse.
REQ-020 SHALL set irq on the cycle after any stable register (dip or key) changes value; a stable reload with an identical value SHALL NOT set irq.
REQ-021 SHALL clear irq on the edge where irq_ack=1, unless a new set event occurs on the same edge, in which case set wins and irq stays 1.
REQ-022 SHALL ignore irq_ack while irq=0.
REQ-023 SHALL update all outputs synchronously; they hold their values between updates.

Reset
REQ-024 SHALL, while reset=0, drive sync1, sync2, candidate and stable registers to all ones (released/off), counters to 0, key_press to 0 and irq to 0.
REQ-025 SHALL restart debouncing from that reset state when reset is asserted mid-count, discarding any partially qualified value.
REQ-026 SHALL begin normal operation on the first rising edge after reset returns to 1; dip_stable = 64'hFFFF_FFFF_FFFF_FFFF until a group qualifies.

Verification (STABLE_CYCLES=4)
REQ-027 SHALL cover clean change: dip_raw byte 0 set to 8'h5A, all else held at 1 -> dip_stable[7:0]=8'h5A exactly at edge 7 after first sampling, irq=1 on the following cycle, other bytes remain 8'hFF.
REQ-028 SHALL cover bounce: key_raw[0] toggling 0/1 every 2 cycles for 20 cycles, then held at 0 -> key_stable[0] changes once, 7 edges after the final toggle, with exactly one key_press[0] pulse.
REQ-029 SHALL cover glitch rejection: dip_raw[63] pulsed to 0 for 3 cycles -> dip_stable unchanged, irq stays 0.
REQ-030 SHALL cover the ack race: irq_ack=1 on the same edge that a new stable change sets irq -> irq remains 1; a later lone ack -> irq=0.
REQ-031 SHALL cover reset mid-count: reset=0 asserted asynchronously 2 cycles into qualifying 8'h00 on byte 3 -> outputs immediately return to reset values; after release with byte 3 still 8'h00, the full 7-edge latency applies again.
REQ-032 SHALL cover group independence: byte 1 changed continuously while byte 2 changes once -> byte 2 qualifies at edge 7, byte 1 never qualifies.
